// File: rtl/vga_output_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : vga_output_if
// Purpose : Pixel FIFO read port between the output frame FIFO and the VGA
//           output stage. The video stage is the master (it issues pops),
//           the FIFO is the slave (it supplies data one cycle after a pop).
// Signals : fifo_read_data    - FIFO output word, valid the cycle after a pop
//           fifo_empty        - FIFO holds no data
//           fifo_read_request - pop one word this cycle
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface vga_output_if #(
  parameter int PIXEL_SIZE = 16
);
  logic [PIXEL_SIZE-1:0] fifo_read_data;
  logic                  fifo_empty;
  logic                  fifo_read_request;

  modport master (
    input  fifo_read_data,
    input  fifo_empty,
    output fifo_read_request
  );

  modport slave (
    output fifo_read_data,
    output fifo_empty,
    input  fifo_read_request
  );
endinterface
`default_nettype wire

// File: rtl/vga_output.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : vga_output
// Purpose : VGA timing generator and pixel streamer. Free-running x/y counters
//           produce HSYNC/VSYNC; in RUN one FIFO word is popped per active
//           pixel and presented to the DAC with a fixed two-cycle latency.
// Ports   : hw_pixel_clk   - pixel clock (only clock)
//           rst            - synchronous active-high reset
//           enable         - request to stream frames from the FIFO
//           fifo           - FIFO read port (master side)
//           hw_rgb_out     - registered pixel to the DAC
//           hw_hsync_out   - registered horizontal sync
//           hw_vsync_out   - registered vertical sync
//           pixel_x/_y     - counter position currently being fetched
//           frame_start    - one-cycle pulse while counters are (0,0)
//           fifo_underflow - sticky: a required pop found the FIFO empty
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module vga_output #(
  parameter int PRECISION        = 11,
  parameter int PIXEL_SIZE       = 16,
  parameter int X_RES            = 800,
  parameter int Y_RES            = 600,
  parameter int H_SYNC           = 128,
  parameter int V_SYNC           = 4,
  parameter int H_FRONT_PORCH    = 40,
  parameter int V_FRONT_PORCH    = 1,
  parameter int H_BACK_PORCH     = 88,
  parameter int V_BACK_PORCH     = 23,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  wire logic                  hw_pixel_clk,
  input  wire logic                  rst,
  input  wire logic                  enable,
  vga_output_if.master               fifo,
  output logic [PIXEL_SIZE-1:0]      hw_rgb_out,
  output logic                       hw_hsync_out,
  output logic                       hw_vsync_out,
  output logic [PRECISION-1:0]       pixel_x,
  output logic [PRECISION-1:0]       pixel_y,
  output logic                       frame_start,
  output logic                       fifo_underflow
);

  localparam int H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  localparam logic [PRECISION-1:0] c_H_LAST   = PRECISION'(H_TOTAL - 1);
  localparam logic [PRECISION-1:0] c_V_LAST   = PRECISION'(V_TOTAL - 1);
  localparam logic [PRECISION-1:0] c_X_RES    = PRECISION'(X_RES);
  localparam logic [PRECISION-1:0] c_Y_RES    = PRECISION'(Y_RES);
  localparam logic [PRECISION-1:0] c_HS_START = PRECISION'(X_RES + H_FRONT_PORCH);
  localparam logic [PRECISION-1:0] c_HS_END   = PRECISION'(X_RES + H_FRONT_PORCH + H_SYNC);
  localparam logic [PRECISION-1:0] c_VS_START = PRECISION'(Y_RES + V_FRONT_PORCH);
  localparam logic [PRECISION-1:0] c_VS_END   = PRECISION'(Y_RES + V_FRONT_PORCH + V_SYNC);

  localparam logic c_SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
  localparam logic c_SYNC_OFF = ~c_SYNC_ON;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [PRECISION-1:0]  r_x;
  logic [PRECISION-1:0]  r_y;
  logic                  w_x_last;
  logic                  w_frame_last;
  logic                  w_active;
  logic                  w_hs_region;
  logic                  w_vs_region;
  logic                  w_read;
  logic                  w_underflow_now;

  // Stage 1: read-issued flag and sync regions aligned with the FIFO data.
  logic                  r_s1_read;
  logic                  r_s1_hs;
  logic                  r_s1_vs;

  // Stage 2: pin registers.
  logic [PIXEL_SIZE-1:0] r_rgb;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_frame_start;
  logic                  r_underflow;

  assign w_x_last     = (r_x == c_H_LAST);
  assign w_frame_last = w_x_last && (r_y == c_V_LAST);
  assign w_active     = (r_x < c_X_RES) && (r_y < c_Y_RES);
  assign w_hs_region  = (r_x >= c_HS_START) && (r_x < c_HS_END);
  assign w_vs_region  = (r_y >= c_VS_START) && (r_y < c_VS_END);

  // A pixel with no data is skipped rather than stalled so timing never slips.
  assign w_read          = (r_state == S_RUN) && w_active && !fifo.fifo_empty;
  assign w_underflow_now = (r_state == S_RUN) && w_active &&  fifo.fifo_empty;

  assign fifo.fifo_read_request = w_read;

  // Free-running position counters.
  always_ff @(posedge hw_pixel_clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // State changes only on the last pixel of a frame, so RUN begins at (0,0)
  // and a mid-frame disable still completes the frame in progress.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_last && enable && !fifo.fifo_empty) w_state_next = S_RUN;
      S_RUN:   if (w_frame_last && !enable)                     w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (rst) begin
      r_s1_read     <= 1'b0;
      r_s1_hs       <= 1'b0;
      r_s1_vs       <= 1'b0;
      r_rgb         <= '0;
      r_hsync       <= c_SYNC_OFF;
      r_vsync       <= c_SYNC_OFF;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_s1_read     <= w_read;
      r_s1_hs       <= w_hs_region;
      r_s1_vs       <= w_vs_region;
      // FIFO data is valid exactly while the stage-1 read flag is set.
      r_rgb         <= r_s1_read ? fifo.fifo_read_data : '0;
      r_hsync       <= r_s1_hs ? c_SYNC_ON : c_SYNC_OFF;
      r_vsync       <= r_s1_vs ? c_SYNC_ON : c_SYNC_OFF;
      // Loaded on the wrap edge, so it is high while the counters sit at (0,0)
      // and the (0,0) produced by reset does not pulse.
      r_frame_start <= w_frame_last;
      r_underflow   <= r_underflow | w_underflow_now;
    end
  end

  assign hw_rgb_out     = r_rgb;
  assign hw_hsync_out   = r_hsync;
  assign hw_vsync_out   = r_vsync;
  assign pixel_x        = r_x;
  assign pixel_y        = r_y;
  assign frame_start    = r_frame_start;
  assign fifo_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_output.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_vga_output
// Purpose : Self-checking bench for vga_output using a reduced timing set.
//           Two instances (sync active high / active low) share stimulus.
//           Expected pin values are queued when each pixel is fetched and
//           popped two cycles later when the DUT presents them.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_vga_output;

  localparam int PREC = 11;
  localparam int PSZ  = 16;
  localparam int XR   = 8;
  localparam int YR   = 4;
  localparam int HFP  = 2;
  localparam int HS   = 3;
  localparam int HBP  = 2;
  localparam int VFP  = 1;
  localparam int VS   = 2;
  localparam int VBP  = 1;
  localparam int HT   = XR + HFP + HS + HBP;
  localparam int VT   = YR + VFP + VS + VBP;

  typedef struct packed {
    logic [PSZ-1:0] rgb;
    logic           hs;
    logic           vs;
  } exp_t;

  logic clk;
  logic rst;
  logic enable;

  logic [PSZ-1:0]  rgb_hi, rgb_lo;
  logic            hs_hi, hs_lo, vs_hi, vs_lo;
  logic [PREC-1:0] x_hi, x_lo, y_hi, y_lo;
  logic            fs_hi, fs_lo, und_hi, und_lo;

  vga_output_if #(.PIXEL_SIZE(PSZ)) if_hi ();
  vga_output_if #(.PIXEL_SIZE(PSZ)) if_lo ();

  vga_output #(
    .PRECISION(PREC), .PIXEL_SIZE(PSZ), .X_RES(XR), .Y_RES(YR),
    .H_SYNC(HS), .V_SYNC(VS), .H_FRONT_PORCH(HFP), .V_FRONT_PORCH(VFP),
    .H_BACK_PORCH(HBP), .V_BACK_PORCH(VBP), .SYNC_ACTIVE_HIGH(1)
  ) u_dut_hi (
    .hw_pixel_clk(clk), .rst(rst), .enable(enable), .fifo(if_hi.master),
    .hw_rgb_out(rgb_hi), .hw_hsync_out(hs_hi), .hw_vsync_out(vs_hi),
    .pixel_x(x_hi), .pixel_y(y_hi), .frame_start(fs_hi),
    .fifo_underflow(und_hi)
  );

  vga_output #(
    .PRECISION(PREC), .PIXEL_SIZE(PSZ), .X_RES(XR), .Y_RES(YR),
    .H_SYNC(HS), .V_SYNC(VS), .H_FRONT_PORCH(HFP), .V_FRONT_PORCH(VFP),
    .H_BACK_PORCH(HBP), .V_BACK_PORCH(VBP), .SYNC_ACTIVE_HIGH(0)
  ) u_dut_lo (
    .hw_pixel_clk(clk), .rst(rst), .enable(enable), .fifo(if_lo.master),
    .hw_rgb_out(rgb_lo), .hw_hsync_out(hs_lo), .hw_vsync_out(vs_lo),
    .pixel_x(x_lo), .pixel_y(y_lo), .frame_start(fs_lo),
    .fifo_underflow(und_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  int       mx, my;
  bit       mrun, mund, mfs;
  exp_t     q[$];
  logic [PSZ-1:0] fifo_cnt;
  bit       prev_req;
  int       n_req_frame;

  task automatic model_reset();
    mx = 0; my = 0; mrun = 0; mund = 0; mfs = 0;
    prev_req = 0;
    q.delete();
    // Pipeline is cleared: two cycles of blank pixels with inactive sync.
    q.push_back('{rgb: '0, hs: 1'b0, vs: 1'b0});
    q.push_back('{rgb: '0, hs: 1'b0, vs: 1'b0});
  endtask

  // One pixel clock: drive inputs just after the edge, check mid-cycle,
  // then advance the model and wait for the next edge.
  task automatic step(input bit en, input bit emp, input bit rs);
    bit   act, ereq, last;
    exp_t e, n;
    enable = en;
    rst    = rs;
    if_hi.fifo_empty = emp;
    if_lo.fifo_empty = emp;
    // Data follows a pop by one cycle; otherwise drive garbage that must
    // never reach the pins.
    if_hi.fifo_read_data = prev_req ? fifo_cnt - 1'b1 : 16'hDEAD;
    if_lo.fifo_read_data = if_hi.fifo_read_data;
    #1;
    act  = (mx < XR) && (my < YR);
    ereq = mrun && act && !emp;
    chk("req_hi", 32'(if_hi.fifo_read_request), 32'(ereq));
    chk("req_lo", 32'(if_lo.fifo_read_request), 32'(ereq));
    chk("pixel_x", 32'(x_hi), 32'(mx));
    chk("pixel_y", 32'(y_hi), 32'(my));
    chk("frame_start", 32'(fs_hi), 32'(mfs));
    chk("underflow", 32'(und_hi), 32'(mund));
    chk("underflow_lo", 32'(und_lo), 32'(mund));
    e = q.pop_front();
    chk("rgb_hi", 32'(rgb_hi), 32'(e.rgb));
    chk("rgb_lo", 32'(rgb_lo), 32'(e.rgb));
    chk("hsync_hi", 32'(hs_hi), 32'(e.hs));
    chk("vsync_hi", 32'(vs_hi), 32'(e.vs));
    chk("hsync_lo", 32'(hs_lo), 32'(!e.hs));
    chk("vsync_lo", 32'(vs_lo), 32'(!e.vs));
    if (ereq) n_req_frame++;

    n.rgb = ereq ? fifo_cnt : '0;
    n.hs  = (mx >= XR + HFP) && (mx < XR + HFP + HS);
    n.vs  = (my >= YR + VFP) && (my < YR + VFP + VS);
    q.push_back(n);
    prev_req = ereq;
    if (ereq) fifo_cnt++;

    if (rs) begin
      model_reset();
    end else begin
      mund = mund | (mrun && act && emp);
      last = (mx == HT - 1) && (my == VT - 1);
      mfs  = last;
      if (last) begin
        if (!mrun && en && !emp) mrun = 1;
        else if (mrun && !en)    mrun = 0;
      end
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit skip_once;
    bit emp;
    int guard;
    int reqs_run;
    fifo_cnt = 16'h0100;
    n_req_frame = 0;
    enable = 0; rst = 1;
    if_hi.fifo_empty = 0; if_lo.fifo_empty = 0;
    if_hi.fifo_read_data = '0; if_lo.fifo_read_data = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    // Idle timing: syncs only, no pops, blank pixels.
    repeat (2 * HT * VT) step(0, 0, 0);
    chk("idle_no_reads", 32'(n_req_frame), 32'd0);

    // Start streaming; first boundary sees an empty FIFO so the start is
    // deferred by one frame. Underflow injected at y=1, x=3..5.
    skip_once = 1;
    n_req_frame = 0;
    repeat (3 * HT * VT) begin
      emp = 0;
      if (!mrun && skip_once && mx == HT - 1 && my == VT - 1) begin
        emp = 1;
        skip_once = 0;
      end
      if (mrun && my == 1 && mx >= 3 && mx <= 5) emp = 1;
      step(1, emp, 0);
    end
    // Streaming ran for at least one full frame with 3 skipped pixels each.
    chk("stream_active", 32'(n_req_frame > 0), 32'd1);
    chk("underflow_sticky", 32'(und_hi), 32'd1);

    // Disable mid-frame at y=2: the frame completes, then no more pops.
    guard = 0;
    while (!(mrun && my == 2) && guard < 4 * HT * VT) begin
      step(1, 0, 0);
      guard++;
    end
    chk("reached_disable_point", 32'(mrun && my == 2), 32'd1);
    n_req_frame = 0;
    repeat (HT * VT) step(0, 0, 0);
    // Remaining lines 2..3 of the frame: 2 lines of XR pops.
    chk("disable_finishes_frame", 32'(n_req_frame), 32'(2 * XR));
    n_req_frame = 0;
    repeat (HT * VT) step(0, 0, 0);
    chk("disabled_no_reads", 32'(n_req_frame), 32'd0);

    // Reset mid-line while streaming.
    guard = 0;
    while (!(mrun && my == 2 && mx == 5) && guard < 4 * HT * VT) begin
      step(1, 0, 0);
      guard++;
    end
    reqs_run = int'(mrun);
    chk("reached_reset_point", 32'(reqs_run), 32'd1);
    step(1, 0, 1);
    n_req_frame = 0;
    repeat (HT * VT + 20) step(0, 0, 0);
    chk("after_reset_no_reads", 32'(n_req_frame), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
